// File: rtl/m_stage_ctrl_pkg.sv
// Shared encodings for the memory-stage controller: instruction types,
// load/store size codes and FSM state encoding.
package m_stage_ctrl_pkg;

  localparam logic [1:0] INSTR_TYPE_ALU   = 2'b00;
  localparam logic [1:0] INSTR_TYPE_LOAD  = 2'b01;
  localparam logic [1:0] INSTR_TYPE_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/m_stage_ctrl_if.sv
// Data-cache request/response bundle between the memory stage (master)
// and the data cache (slave).
interface m_stage_ctrl_if #(
  parameter int WORD_SIZE = 32
);
  logic                 dc_req_valid;
  logic                 dc_req_write;
  logic [WORD_SIZE-1:0] dc_req_addr;
  logic [WORD_SIZE-1:0] dc_req_wdata;
  logic [3:0]           dc_req_be;
  logic                 dc_req_ready;
  logic                 dc_resp_valid;
  logic [WORD_SIZE-1:0] dc_resp_rdata;

  modport master (
    output dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_be,
    input  dc_req_ready, dc_resp_valid, dc_resp_rdata
  );

  modport slave (
    input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_be,
    output dc_req_ready, dc_resp_valid, dc_resp_rdata
  );
endinterface

// File: rtl/m_stage_align.sv
// Combinational byte-lane logic: misalignment/illegal-size detection,
// store lane replication and byte enables, load extraction and extension.
module m_stage_align
  import m_stage_ctrl_pkg::*;
(
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic [31:0] o_req_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_load_data
);
  logic [1:0]  w_lane;
  logic [31:0] w_shifted;

  assign w_lane     = i_addr[1:0];
  assign o_req_addr = {i_addr[31:2], 2'b00};
  assign w_shifted  = i_rdata >> {w_lane, 3'b000};

  always_comb begin
    o_misaligned = ((i_funct3[1:0] == F3_H[1:0]) & i_addr[0]) |
                   ((i_funct3[1:0] == F3_W[1:0]) & (|i_addr[1:0]));
    o_illegal = 1'b0;
    if (i_is_load)
      o_illegal = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
    else if (i_is_store)
      o_illegal = (i_funct3 > F3_W);
  end

  // Store data is replicated across lanes so the cache only needs the enables.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      F3_B[1:0]: begin
        o_be    = 4'b0001 << w_lane;
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H[1:0]: begin
        o_be    = 4'b0011 << w_lane;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/m_stage_ctrl.sv
// Memory-stage controller: drives data-cache requests straight from the E/M
// register, stalls it until the access completes, and registers one wb record.
//   state   | meaning
//   IDLE    | evaluate E/M record; retire ALU/bad ops directly
//   REQ     | cache request presented, waiting for ready
//   WAIT    | load accepted, waiting for response data
module m_stage_ctrl
  import m_stage_ctrl_pkg::*;
#(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [2:0]                 in_funct3,
  input  logic [WORD_SIZE-1:0]       in_alu_result,
  input  logic [WORD_SIZE-1:0]       in_s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       stall,
  m_stage_ctrl_if.master             dc,
  output logic                       wb_valid,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic [WORD_SIZE-1:0]       wb_pc,
  output logic [WORD_SIZE-1:0]       wb_result,
  output logic                       wb_exception
);
  state_e r_state, w_next;
  logic   r_kill;
  logic   w_is_load, w_is_store, w_mem, w_bad, w_mis, w_ill;
  logic   w_req_valid, w_done, w_retire;
  logic [WORD_SIZE-1:0] w_load_data, w_wb_result;

  assign w_is_load  = (in_instruction_type == INSTR_TYPE_LOAD);
  assign w_is_store = (in_instruction_type == INSTR_TYPE_STORE);
  assign w_mem      = w_is_load | w_is_store;
  assign w_bad      = w_mem & (w_mis | w_ill);

  m_stage_align u_align (
    .i_is_load    (w_is_load),
    .i_is_store   (w_is_store),
    .i_funct3     (in_funct3),
    .i_addr       (in_alu_result),
    .i_store_data (in_s2),
    .i_rdata      (dc.dc_resp_rdata),
    .o_misaligned (w_mis),
    .o_illegal    (w_ill),
    .o_req_addr   (dc.dc_req_addr),
    .o_wdata      (dc.dc_req_wdata),
    .o_be         (dc.dc_req_be),
    .o_load_data  (w_load_data)
  );

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_done      = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_mem & !w_bad) w_next = ST_REQ;
          else                w_retire = 1'b1;
        end
      end
      ST_REQ: begin
        if (!in_valid) begin
          w_next = ST_IDLE;
        end else begin
          w_req_valid = 1'b1;
          if (dc.dc_req_ready) begin
            if (w_is_store) begin
              w_done = 1'b1;
              w_next = ST_IDLE;
            end else begin
              w_next = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (dc.dc_resp_valid) begin
          w_next = ST_IDLE;
          w_done = in_valid & !r_kill;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // A killed load still owes a response; hold any new record until it drains.
  assign stall = !reset & in_valid &
                 ((w_mem & !w_bad & !w_done) | ((r_state == ST_WAIT) & r_kill));

  assign dc.dc_req_valid = w_req_valid & !reset;
  assign dc.dc_req_write = w_is_store;

  always_comb begin
    w_wb_result = '0;
    if (r_state == ST_WAIT)
      w_wb_result = w_load_data;
    else if (r_state == ST_IDLE && !w_bad && in_instruction_type == INSTR_TYPE_ALU)
      w_wb_result = in_alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_kill       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rob_id    <= '0;
      wb_pc        <= '0;
      wb_result    <= '0;
      wb_exception <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_WAIT && !dc.dc_resp_valid && !in_valid) r_kill <= 1'b1;
      else if (w_next != ST_WAIT)                               r_kill <= 1'b0;
      wb_valid <= w_retire | w_done;
      if (w_retire | w_done) begin
        wb_rob_id    <= in_rob_id;
        wb_pc        <= in_pc;
        wb_result    <= w_wb_result;
        wb_exception <= w_retire & w_bad;
      end
    end
  end
endmodule

// File: tb/tb_m_stage_ctrl.sv
// Directed bench for m_stage_ctrl: ALU, store lanes, load extension,
// exceptions, mid-load reset, dropped in_valid and back-to-back retirement.
module tb_m_stage_ctrl;
  import m_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_instruction_type;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_s2;
  logic [2:0]  in_rob_id;
  logic        stall;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_pc;
  logic [31:0] wb_result;
  logic        wb_exception;

  int n_cmp = 0;
  int n_mis = 0;

  m_stage_ctrl_if #(.WORD_SIZE(32)) dc_if ();

  m_stage_ctrl #(.WORD_SIZE(32), .INSTR_TYPE_SZ(2), .ROB_ENTRY_WIDTH(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_instruction_type (in_instruction_type),
    .in_pc               (in_pc),
    .in_funct3           (in_funct3),
    .in_alu_result       (in_alu_result),
    .in_s2               (in_s2),
    .in_rob_id           (in_rob_id),
    .stall               (stall),
    .dc                  (dc_if),
    .wb_valid            (wb_valid),
    .wb_rob_id           (wb_rob_id),
    .wb_pc               (wb_pc),
    .wb_result           (wb_result),
    .wb_exception        (wb_exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] ty, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] s2, input logic [2:0] rob);
    in_valid            = 1'b1;
    in_instruction_type = ty;
    in_funct3           = f3;
    in_alu_result       = addr;
    in_s2               = s2;
    in_rob_id           = rob;
    in_pc               = 32'h0000_0400 + {29'd0, rob};
  endtask

  // Load with response arriving in the third cycle after the handshake.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp, input logic [2:0] rob);
    set_op(INSTR_TYPE_LOAD, f3, addr, 32'h0, rob);
    dc_if.dc_req_ready = 1'b1;
    #1 chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
    tick();
    chk({tag, "_req_valid"}, {31'd0, dc_if.dc_req_valid}, 32'd1);
    chk({tag, "_req_addr"}, dc_if.dc_req_addr, {addr[31:2], 2'b00});
    tick();
    dc_if.dc_req_ready = 1'b0;
    #1 chk({tag, "_wait_noreq"}, {31'd0, dc_if.dc_req_valid}, 32'd0);
    tick();
    tick();
    dc_if.dc_resp_valid = 1'b1;
    dc_if.dc_resp_rdata = rdata;
    #1 chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    tick();
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_result"}, wb_result, exp);
    chk({tag, "_wb_rob"}, {29'd0, wb_rob_id}, {29'd0, rob});
    in_valid = 1'b0;
    dc_if.dc_resp_valid = 1'b0;
    tick();
    chk({tag, "_wb_pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic run_bad(input string tag, input logic [1:0] ty, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [2:0] rob);
    set_op(ty, f3, addr, 32'hFFFF_FFFF, rob);
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_noreq"}, {31'd0, dc_if.dc_req_valid}, 32'd0);
    tick();
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_exc"}, {31'd0, wb_exception}, 32'd1);
    chk({tag, "_wb_result"}, wb_result, 32'd0);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instruction_type = 2'b00; in_pc = '0; in_funct3 = '0;
    in_alu_result = '0; in_s2 = '0; in_rob_id = '0;
    dc_if.dc_req_ready = 1'b0; dc_if.dc_resp_valid = 1'b0; dc_if.dc_resp_rdata = '0;
    tick();
    tick();
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_wb_exc", {31'd0, wb_exception}, 32'd0);
    chk("rst_req_valid", {31'd0, dc_if.dc_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    tick();

    // ALU retire
    set_op(INSTR_TYPE_ALU, 3'b000, 32'h0000_1234, 32'h0, 3'd5);
    #1 chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_wb_result", wb_result, 32'h0000_1234);
    chk("alu_wb_rob", {29'd0, wb_rob_id}, 32'd5);
    chk("alu_wb_pc", wb_pc, 32'h0000_0405);
    in_valid = 1'b0;
    tick();
    chk("alu_wb_pulse", {31'd0, wb_valid}, 32'd0);
    chk("alu_wb_hold", wb_result, 32'h0000_1234);

    // response outside WAIT is ignored
    dc_if.dc_resp_valid = 1'b1;
    tick();
    chk("stray_resp", {31'd0, wb_valid}, 32'd0);
    dc_if.dc_resp_valid = 1'b0;

    // SB with ready held low two cycles
    set_op(INSTR_TYPE_STORE, F3_B, 32'h0000_1003, 32'h0000_00AB, 3'd1);
    #1 chk("sb_stall_idle", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sb_req_valid", {31'd0, dc_if.dc_req_valid}, 32'd1);
      chk("sb_req_write", {31'd0, dc_if.dc_req_write}, 32'd1);
      chk("sb_req_addr", dc_if.dc_req_addr, 32'h0000_1000);
      chk("sb_req_be", {28'd0, dc_if.dc_req_be}, 32'h8);
      chk("sb_req_wdata", dc_if.dc_req_wdata, 32'hABAB_ABAB);
      chk("sb_stall", {31'd0, stall}, 32'd1);
      chk("sb_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    dc_if.dc_req_ready = 1'b1;
    #1 chk("sb_stall_done", {31'd0, stall}, 32'd0);
    tick();
    chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sb_wb_result", wb_result, 32'd0);
    chk("sb_wb_rob", {29'd0, wb_rob_id}, 32'd1);
    chk("sb_wb_exc", {31'd0, wb_exception}, 32'd0);
    in_valid = 1'b0;
    dc_if.dc_req_ready = 1'b0;
    tick();
    chk("sb_wb_pulse", {31'd0, wb_valid}, 32'd0);

    // load extension
    run_load("lb", F3_B, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80, 3'd2);
    run_load("lbu", F3_BU, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080, 3'd3);
    run_load("lh", F3_H, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001, 3'd4);
    run_load("lhu", F3_HU, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001, 3'd6);

    // exceptions
    run_bad("lw_mis", INSTR_TYPE_LOAD, F3_W, 32'h0000_2002, 3'd1);
    run_bad("lh_mis", INSTR_TYPE_LOAD, F3_H, 32'h0000_2003, 3'd2);
    run_bad("ld_ill", INSTR_TYPE_LOAD, 3'b011, 32'h0000_2000, 3'd3);
    run_bad("st_ill", INSTR_TYPE_STORE, 3'b100, 32'h0000_2000, 3'd4);

    // reset while a load waits; later response must not retire
    set_op(INSTR_TYPE_LOAD, F3_W, 32'h0000_3000, 32'h0, 3'd3);
    dc_if.dc_req_ready = 1'b1;
    tick();
    tick();
    dc_if.dc_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstw_req_valid", {31'd0, dc_if.dc_req_valid}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    dc_if.dc_resp_valid = 1'b1;
    dc_if.dc_resp_rdata = 32'h1234_5678;
    tick();
    chk("rstw_late_resp", {31'd0, wb_valid}, 32'd0);
    dc_if.dc_resp_valid = 1'b0;
    tick();
    chk("rstw_idle_stall", {31'd0, stall}, 32'd0);

    // back-to-back SW then LW
    set_op(INSTR_TYPE_STORE, F3_W, 32'h0000_0040, 32'hDEAD_BEEF, 3'd4);
    dc_if.dc_req_ready = 1'b1;
    tick();
    chk("b2b_sw_be", {28'd0, dc_if.dc_req_be}, 32'hF);
    chk("b2b_sw_wdata", dc_if.dc_req_wdata, 32'hDEAD_BEEF);
    chk("b2b_sw_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("b2b_sw_wb", {31'd0, wb_valid}, 32'd1);
    chk("b2b_sw_rob", {29'd0, wb_rob_id}, 32'd4);
    set_op(INSTR_TYPE_LOAD, F3_W, 32'h0000_0044, 32'h0, 3'd6);
    #1 chk("b2b_lw_idle_noreq", {31'd0, dc_if.dc_req_valid}, 32'd0);
    tick();
    chk("b2b_lw_nowb", {31'd0, wb_valid}, 32'd0);
    chk("b2b_lw_req", {31'd0, dc_if.dc_req_valid}, 32'd1);
    chk("b2b_lw_addr", dc_if.dc_req_addr, 32'h0000_0044);
    tick();
    dc_if.dc_resp_valid = 1'b1;
    dc_if.dc_resp_rdata = 32'h1122_3344;
    #1 chk("b2b_lw_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("b2b_lw_wb", {31'd0, wb_valid}, 32'd1);
    chk("b2b_lw_result", wb_result, 32'h1122_3344);
    chk("b2b_lw_rob", {29'd0, wb_rob_id}, 32'd6);
    in_valid = 1'b0;
    dc_if.dc_resp_valid = 1'b0;
    dc_if.dc_req_ready = 1'b0;
    tick();
    chk("b2b_no_dup", {31'd0, wb_valid}, 32'd0);

    // SH lanes, then in_valid drops in REQ
    set_op(INSTR_TYPE_STORE, F3_H, 32'h0000_1002, 32'h0000_BEEF, 3'd7);
    tick();
    chk("sh_be", {28'd0, dc_if.dc_req_be}, 32'hC);
    chk("sh_wdata", dc_if.dc_req_wdata, 32'hBEEF_BEEF);
    in_valid = 1'b0;
    #1 chk("drop_req_noreq", {31'd0, dc_if.dc_req_valid}, 32'd0);
    dc_if.dc_req_ready = 1'b1;
    tick();
    chk("drop_req_nowb", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("drop_req_nowb2", {31'd0, wb_valid}, 32'd0);

    // in_valid drops in WAIT; response dropped, then ALU retires normally
    set_op(INSTR_TYPE_LOAD, F3_W, 32'h0000_0060, 32'h0, 3'd2);
    tick();
    tick();
    dc_if.dc_req_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    dc_if.dc_resp_valid = 1'b1;
    dc_if.dc_resp_rdata = 32'hCAFE_F00D;
    tick();
    chk("drop_wait_nowb", {31'd0, wb_valid}, 32'd0);
    dc_if.dc_resp_valid = 1'b0;
    set_op(INSTR_TYPE_ALU, 3'b000, 32'h0000_0777, 32'h0, 3'd7);
    tick();
    chk("post_drop_alu_wb", {31'd0, wb_valid}, 32'd1);
    chk("post_drop_alu_res", wb_result, 32'h0000_0777);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/m_stage_ctrl.md
Name: m_stage_ctrl

Overview:
- Memory-stage controller; consumes the execute→memory pipeline register outputs and drives the stall back into that register.
- Issues load/store requests to the data cache over a valid/ready request and valid response handshake.
- Performs load extension, store byte-enable/lane generation and misalignment detection.
- Emits one registered writeback record per retired instruction towards the ROB.

Parameters:
- WORD_SIZE, 32, datapath/address width.
- INSTR_TYPE_SZ, 2, width of instruction type field.
- ROB_ENTRY_WIDTH, 3, ROB tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  E/M record valid
- in_instruction_type  in  INSTR_TYPE_SZ  ALU / LOAD / STORE
- in_pc  in  WORD_SIZE  instruction PC
- in_funct3  in  3  access size/sign
- in_alu_result  in  WORD_SIZE  ALU result or effective address
- in_s2  in  WORD_SIZE  store data
- in_rob_id  in  ROB_ENTRY_WIDTH  ROB tag
- stall  out  1  hold E/M register
- dc_req_valid  out  1  cache request valid
- dc_req_write  out  1  1 = store
- dc_req_addr  out  WORD_SIZE  word-aligned address (addr[1:0] = 0)
- dc_req_wdata  out  WORD_SIZE  lane-replicated store data
- dc_req_be  out  4  byte enables
- dc_req_ready  in  1  cache accepts request
- dc_resp_valid  in  1  load data valid
- dc_resp_rdata  in  WORD_SIZE  load word
- wb_valid  out  1  writeback valid
- wb_rob_id  out  ROB_ENTRY_WIDTH  tag
- wb_pc  out  WORD_SIZE  PC
- wb_result  out  WORD_SIZE  result (0 for stores/exceptions)
- wb_exception  out  1  misaligned or illegal funct3

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE; registered wb_* all 0. dc_req_valid=0 and stall=0 follow combinationally.
- FSM states: IDLE, REQ, WAIT. The block works directly on in_* (E/M holds them stable under stall); it stores no copy of the instruction.
- Classification: mem = LOAD|STORE.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores >010.
- Bad = misaligned|illegal.
- done = (STORE & state==REQ & dc_req_ready) | (LOAD & state==WAIT & dc_resp_valid).
- stall = in_valid & mem & !bad & !done (combinational).
- IDLE:
  - in_valid & (ALU | bad) → registered wb next cycle, stall=0, stay IDLE. ALU: wb_result=in_alu_result. Bad: wb_exception=1, no cache request.
  - in_valid & mem & !bad → REQ.
- REQ: dc_req_valid=1; address/data/be are combinational from in_*.
  - Handshake on dc_req_valid & dc_req_ready.
  - Store handshake → wb next cycle, IDLE.
  - Load handshake → WAIT.
  - Without ready, hold all request fields stable.
- WAIT: dc_resp_valid → wb next cycle with extended data, IDLE.
- Load extension: lane = addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be=0011<<addr[1:0], wdata = half replicated ×2.
  - SW: be=1111.
- wb_valid is 1 for exactly one cycle per retired instruction; otherwise 0 and other wb fields hold their previous value.
- Latency:
  - ALU/exception: 1 cycle.
  - Store: 1 + request-wait cycles + 1.
  - Load: adds response latency.
  - Back-to-back: the next E/M record is seen the cycle after done.
- in_valid drops in REQ before handshake → IDLE, no request, no wb.
- in_valid drops in WAIT → stay until dc_resp_valid, drop data, no wb.
- dc_resp_valid outside WAIT is ignored.
- Reset mid-operation: reset overrides everything → IDLE; any outstanding response is ignored.

Decomposition:
- Shared package (defines): INSTR_TYPE_ALU/LOAD/STORE encodings, funct3 constants (F3_B/H/W/BU/HU), state encoding.
- One sub-module: m_stage_align. Combinational; holds misalign/illegal detection, be/wdata lane generation and load extraction/extension.
- FSM and wb registers stay in the top.

Test Plan:
- ALU, in_alu_result=0x1234, rob_id=5 → stall=0; next cycle wb_valid=1, wb_result=0x1234, wb_rob_id=5.
- SB addr 0x1003, s2=0x000000AB, ready held low for 2 cycles → stall=1 throughout; dc_req_addr=0x1000, be=1000, wdata=0xABABABAB stable; wb the cycle after ready.
- LB addr 0x2001, rdata=0x0000_8000 after 3-cycle latency → wb_result=0xFFFFFF80. Same with LBU → 0x00000080.
- LW addr 0x2002 → no dc_req_valid, stall=0, next cycle wb_exception=1. Repeat with LH addr 0x2003, and with load funct3=011.
- Load in WAIT, reset asserted → next cycle state IDLE, wb_valid=0. A later dc_resp_valid produces no wb.
- Back-to-back SW then LW, both ready=1, latency 1 → stores retire every 2 cycles, the load in 3; no duplicate wb.
